// File: rtl/accumulator_command_sequencer.sv
// Command front-end for the signed accumulator: turns ready/valid commands into single-cycle pulses
// and returns the result on a ready/valid port. Optional WAIT timeout: ACCUMULATOR_COMMAND_SEQUENCER_TIMEOUT_EN.
module accumulator_command_sequencer #(
   parameter int unsigned WORD_WIDTH        = 8,
   parameter int unsigned EXTRA_PIPE_STAGES = 0,
   parameter int unsigned TIMEOUT_CYCLES    = 64
) (
   input  logic                  clock_i,
   input  logic                  clear_i,
   input  logic                  input_valid_i,
   output logic                  input_ready_o,
   input  logic [1:0]            input_op_i,
   input  logic [WORD_WIDTH-1:0] input_data_i,
   output logic                  acc_increment_valid_o,
   output logic [WORD_WIDTH-1:0] acc_increment_value_o,
   output logic                  acc_load_valid_o,
   output logic [WORD_WIDTH-1:0] acc_load_value_o,
   output logic                  acc_clear_o,
   output logic                  acc_carry_in_o,
   input  logic                  acc_increment_done_i,
   input  logic                  acc_load_done_i,
   input  logic                  acc_clear_done_i,
   input  logic [WORD_WIDTH-1:0] acc_value_i,
   input  logic                  acc_overflow_i,
   input  logic                  acc_carry_out_i,
   output logic                  output_valid_o,
   input  logic                  output_ready_i,
   output logic [WORD_WIDTH-1:0] output_value_o,
   output logic                  output_overflow_o,
   output logic                  output_carry_o,
   output logic                  output_error_o
);

   localparam logic [1:0] OpInc   = 2'b00;
   localparam logic [1:0] OpLoad  = 2'b01;
   localparam logic [1:0] OpClear = 2'b10;
   localparam logic [1:0] OpRead  = 2'b11;

   localparam int unsigned DrainW = $clog2(EXTRA_PIPE_STAGES + 2);
   localparam logic [DrainW-1:0] DrainInit = DrainW'(EXTRA_PIPE_STAGES + 1);
   localparam logic [DrainW-1:0] DrainOne  = DrainW'(1);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [2:0] {
      StDrain,
      StIdle,
      StWait,
      StCapture,
      StRespond
   } state_e;

   state_e                state_q, state_d;
   logic [DrainW-1:0]     drain_q, drain_d;
   logic [1:0]            op_q, op_d;
   logic [WORD_WIDTH-1:0] data_q, data_d;
   logic                  inc_pulse_q, inc_pulse_d;
   logic                  load_pulse_q, load_pulse_d;
   logic                  clr_pulse_q, clr_pulse_d;
   logic                  valid_q, valid_d;
   logic [WORD_WIDTH-1:0] value_q, value_d;
   logic                  ovf_q, ovf_d;
   logic                  carry_q, carry_d;
   logic                  accept;
   logic                  done_match;
   logic                  capture;

`ifdef ACCUMULATOR_COMMAND_SEQUENCER_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
   localparam logic [TmoW-1:0] TmoOne  = TmoW'(1);

   logic            err_q, err_d;
   logic [TmoW-1:0] tmo_q, tmo_d;
`endif

   assign input_ready_o = (state_q == StIdle) && !clear_i;
   assign accept        = input_valid_i && input_ready_o;

   // Only the done belonging to the op in flight may complete a WAIT.
   always_comb begin
      done_match = 1'b0;
      case (op_q)
         OpInc:   done_match = acc_increment_done_i;
         OpLoad:  done_match = acc_load_done_i;
         OpClear: done_match = acc_clear_done_i;
         default: done_match = 1'b0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      drain_d      = drain_q;
      op_d         = op_q;
      data_d       = data_q;
      inc_pulse_d  = 1'b0;
      load_pulse_d = 1'b0;
      clr_pulse_d  = 1'b0;
      valid_d      = valid_q;
      value_d      = value_q;
      ovf_d        = ovf_q;
      carry_d      = carry_q;
      capture      = 1'b0;
`ifdef ACCUMULATOR_COMMAND_SEQUENCER_TIMEOUT_EN
      err_d        = err_q;
      tmo_d        = tmo_q;
`endif

      unique case (state_q)
         StDrain: begin
            drain_d = drain_q - DrainOne;
            if (drain_q <= DrainOne) begin
               state_d = StIdle;
            end
         end
         StIdle: begin
            if (accept) begin
               op_d   = input_op_i;
               data_d = input_data_i;
`ifdef ACCUMULATOR_COMMAND_SEQUENCER_TIMEOUT_EN
               err_d  = 1'b0;
               tmo_d  = '0;
`endif
               unique case (input_op_i)
                  OpInc: begin
                     inc_pulse_d = 1'b1;
                     state_d     = StWait;
                  end
                  OpLoad: begin
                     load_pulse_d = 1'b1;
                     state_d      = StWait;
                  end
                  OpClear: begin
                     clr_pulse_d = 1'b1;
                     state_d     = StWait;
                  end
                  OpRead: begin
                     state_d = StCapture;
                  end
               endcase
            end
         end
         StWait: begin
            if (done_match) begin
               capture = 1'b1;
            end
`ifdef ACCUMULATOR_COMMAND_SEQUENCER_TIMEOUT_EN
            else if (tmo_q == TmoLast) begin
               capture = 1'b1;
               err_d   = 1'b1;
            end else begin
               tmo_d = tmo_q + TmoOne;
            end
`endif
         end
         StCapture: begin
            capture = 1'b1;
         end
         StRespond: begin
            if (output_ready_i) begin
               valid_d = 1'b0;
               state_d = StIdle;
`ifdef ACCUMULATOR_COMMAND_SEQUENCER_TIMEOUT_EN
               // A timed-out command may still be in the accumulator pipe; flush its done.
               if (err_q) begin
                  state_d = StDrain;
                  drain_d = DrainInit;
               end
`endif
            end
         end
         default: begin
            state_d = StDrain;
            drain_d = DrainInit;
         end
      endcase

      if (capture) begin
         valid_d = 1'b1;
         value_d = acc_value_i;
         ovf_d   = acc_overflow_i;
         carry_d = acc_carry_out_i;
         state_d = StRespond;
      end
   end

   always_ff @(posedge clock_i) begin
      if (clear_i) begin
         state_q      <= StDrain;
         drain_q      <= DrainInit;
         op_q         <= OpInc;
         data_q       <= '0;
         inc_pulse_q  <= 1'b0;
         load_pulse_q <= 1'b0;
         clr_pulse_q  <= 1'b0;
         valid_q      <= 1'b0;
         value_q      <= '0;
         ovf_q        <= 1'b0;
         carry_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         drain_q      <= drain_d;
         op_q         <= op_d;
         data_q       <= data_d;
         inc_pulse_q  <= inc_pulse_d;
         load_pulse_q <= load_pulse_d;
         clr_pulse_q  <= clr_pulse_d;
         valid_q      <= valid_d;
         value_q      <= value_d;
         ovf_q        <= ovf_d;
         carry_q      <= carry_d;
      end
   end

`ifdef ACCUMULATOR_COMMAND_SEQUENCER_TIMEOUT_EN
   always_ff @(posedge clock_i) begin
      if (clear_i) begin
         err_q <= 1'b0;
         tmo_q <= '0;
      end else begin
         err_q <= err_d;
         tmo_q <= tmo_d;
      end
   end

   assign output_error_o = err_q;
`else
   assign output_error_o = 1'b0;
`endif

   assign acc_increment_valid_o = inc_pulse_q;
   assign acc_increment_value_o = data_q;
   assign acc_load_valid_o      = load_pulse_q;
   assign acc_load_value_o      = data_q;
   assign acc_clear_o           = clr_pulse_q;
   assign acc_carry_in_o        = 1'b0;

   assign output_valid_o    = valid_q;
   assign output_value_o    = value_q;
   assign output_overflow_o = ovf_q;
   assign output_carry_o    = carry_q;

endmodule

// File: tb/tb_accumulator_command_sequencer.sv
// Bench for accumulator_command_sequencer: behavioural accumulator responder plus an arithmetic
// reference model of the accumulated value and flags; random and directed command sequences.
module tb_accumulator_command_sequencer;

   localparam int unsigned W   = 8;
   localparam int unsigned EPS = 2;
   localparam int unsigned TMO = 64;

   logic         clk = 1'b0;
   logic         clear = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [1:0]   in_op = 2'b00;
   logic [W-1:0] in_data = '0;
   logic         inc_v, load_v, acc_clr, acc_cin;
   logic [W-1:0] inc_val, load_val;
   logic         fa_inc_done = 1'b0, fa_load_done = 1'b0, fa_clr_done = 1'b0;
   logic         spur_load = 1'b0;
   logic [W-1:0] fa_val = '0;
   logic         fa_ovf = 1'b0, fa_cy = 1'b0;
   logic         out_valid, out_ready = 1'b0;
   logic [W-1:0] out_val;
   logic         out_ovf, out_cy, out_err;
   logic         mute = 1'b0;

   int total = 0;
   int bad   = 0;
   int n_inc = 0, n_load = 0, n_clr = 0;
   int ref_val = 0;
   int ref_ovf = 0;
   int ref_cy  = 0;

   always #5 clk = ~clk;

   accumulator_command_sequencer #(
      .WORD_WIDTH       (W),
      .EXTRA_PIPE_STAGES(EPS),
      .TIMEOUT_CYCLES   (TMO)
   ) dut (
      .clock_i              (clk),
      .clear_i              (clear),
      .input_valid_i        (in_valid),
      .input_ready_o        (in_ready),
      .input_op_i           (in_op),
      .input_data_i         (in_data),
      .acc_increment_valid_o(inc_v),
      .acc_increment_value_o(inc_val),
      .acc_load_valid_o     (load_v),
      .acc_load_value_o     (load_val),
      .acc_clear_o          (acc_clr),
      .acc_carry_in_o       (acc_cin),
      .acc_increment_done_i (fa_inc_done),
      .acc_load_done_i      (fa_load_done | spur_load),
      .acc_clear_done_i     (fa_clr_done),
      .acc_value_i          (fa_val),
      .acc_overflow_i       (fa_ovf),
      .acc_carry_out_i      (fa_cy),
      .output_valid_o       (out_valid),
      .output_ready_i       (out_ready),
      .output_value_o       (out_val),
      .output_overflow_o    (out_ovf),
      .output_carry_o       (out_cy),
      .output_error_o       (out_err)
   );

   // Accumulator stand-in: a pulse seen at one edge completes EPS edges later.
   logic [EPS-1:0] sh_v = '0;
   logic [1:0]     sh_op [EPS];
   logic [W-1:0]   sh_d  [EPS];
   logic [W:0]     fa_sum;
   assign fa_sum = {1'b0, fa_val} + {1'b0, sh_d[EPS-1]};

   always @(posedge clk) begin
      fa_inc_done  <= 1'b0;
      fa_load_done <= 1'b0;
      fa_clr_done  <= 1'b0;
      sh_v[0]  <= !mute && (inc_v || load_v || acc_clr);
      sh_op[0] <= inc_v ? 2'd0 : (load_v ? 2'd1 : 2'd2);
      sh_d[0]  <= inc_v ? inc_val : load_val;
      for (int i = 1; i < EPS; i++) begin
         sh_v[i]  <= sh_v[i-1];
         sh_op[i] <= sh_op[i-1];
         sh_d[i]  <= sh_d[i-1];
      end
      if (sh_v[EPS-1]) begin
         case (sh_op[EPS-1])
            2'd0: begin
               fa_val      <= fa_sum[W-1:0];
               fa_cy       <= fa_sum[W];
               fa_ovf      <= (fa_val[W-1] == sh_d[EPS-1][W-1]) && (fa_sum[W-1] != fa_val[W-1]);
               fa_inc_done <= 1'b1;
            end
            2'd1: begin
               fa_val       <= sh_d[EPS-1];
               fa_cy        <= 1'b0;
               fa_ovf       <= 1'b0;
               fa_load_done <= 1'b1;
            end
            default: begin
               fa_val      <= '0;
               fa_cy       <= 1'b0;
               fa_ovf      <= 1'b0;
               fa_clr_done <= 1'b1;
            end
         endcase
      end
   end

   always @(posedge clk) begin
      if (inc_v)   n_inc  <= n_inc + 1;
      if (load_v)  n_load <= n_load + 1;
      if (acc_clr) n_clr  <= n_clr + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h required=%0h", tag, obs, exp);
      end
   endtask

   // Reference: accumulator semantics in plain integer arithmetic.
   task automatic ref_apply(input logic [1:0] op, input logic [W-1:0] d);
      int sa, sb, ss, us;
      case (op)
         2'd0: begin
            sa = (ref_val >= 128) ? ref_val - 256 : ref_val;
            sb = (int'(d) >= 128) ? int'(d) - 256 : int'(d);
            ss = sa + sb;
            us = ref_val + int'(d);
            ref_ovf = (ss > 127 || ss < -128) ? 1 : 0;
            ref_cy  = (us > 255) ? 1 : 0;
            ref_val = us % 256;
         end
         2'd1: begin
            ref_val = int'(d);
            ref_ovf = 0;
            ref_cy  = 0;
         end
         2'd2: begin
            ref_val = 0;
            ref_ovf = 0;
            ref_cy  = 0;
         end
         default: ;
      endcase
   endtask

   // Returns at the negedge of the cycle after acceptance.
   task automatic accept_cmd(input logic [1:0] op, input logic [W-1:0] d);
      int n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("accept_wait", (n < 100) ? 1 : 0, 1);
      in_valid = 1'b1;
      in_op    = op;
      in_data  = d;
      @(negedge clk);
      in_valid = 1'b0;
      in_op    = 2'($urandom);
      in_data  = W'($urandom);
   endtask

   task automatic send(input logic [1:0] op, input logic [W-1:0] d, input int hold, input bit spur);
      int k, s_inc, s_load, s_clr, exp_lat;
      logic [W-1:0] held;
      ref_apply(op, d);
      s_inc  = n_inc;
      s_load = n_load;
      s_clr  = n_clr;
      accept_cmd(op, d);
      k = 1;
      check("pulse_inc",  inc_v,   (op == 2'd0) ? 1 : 0);
      check("pulse_load", load_v,  (op == 2'd1) ? 1 : 0);
      check("pulse_clr",  acc_clr, (op == 2'd2) ? 1 : 0);
      if (op == 2'd0) check("inc_data", inc_val, d);
      if (op == 2'd1) check("load_data", load_val, d);
      if (spur) spur_load = 1'b1;
      while (!out_valid && k < 200) begin
         @(negedge clk);
         spur_load = 1'b0;
         k++;
      end
      spur_load = 1'b0;
      exp_lat = (op == 2'd3) ? 2 : EPS + 3;
      check("latency", k, exp_lat);
      check("value", out_val, ref_val);
      check("overflow", out_ovf, ref_ovf);
      check("carry", out_cy, ref_cy);
      check("error", out_err, 0);
      held = out_val;
      repeat (hold) begin
         @(negedge clk);
         check("hold_valid", out_valid, 1);
         check("hold_value", out_val, held);
         check("hold_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("valid_drop", out_valid, 0);
      check("n_inc",  n_inc - s_inc,   (op == 2'd0) ? 1 : 0);
      check("n_load", n_load - s_load, (op == 2'd1) ? 1 : 0);
      check("n_clr",  n_clr - s_clr,   (op == 2'd2) ? 1 : 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset and drain release.
      clear = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_ready", in_ready, 0);
      check("rst_valid", out_valid, 0);
      check("rst_pulses", {inc_v, load_v, acc_clr}, 0);
      check("rst_value", out_val, 0);
      check("rst_error", out_err, 0);
      check("carry_in", acc_cin, 0);
      clear = 1'b0;
      #1;
      check("drain_c1", in_ready, 0);
      @(negedge clk);
      check("drain_c2", in_ready, 0);
      @(negedge clk);
      check("drain_c3", in_ready, 0);
      check("drain_nopulse", n_inc + n_load + n_clr, 0);
      @(negedge clk);
      check("drain_idle", in_ready, 1);
      check("drain_novalid", out_valid, 0);

      // Directed arithmetic cases.
      send(2'd1, 8'h10, 0, 1'b0);
      send(2'd0, 8'h05, 0, 1'b0);
      send(2'd1, 8'h7F, 0, 1'b0);
      send(2'd0, 8'h01, 0, 1'b0);
      send(2'd0, 8'h01, 0, 1'b0);
      send(2'd2, 8'hAA, 0, 1'b0);
      send(2'd3, 8'h55, 0, 1'b0);
      send(2'd1, 8'hF0, 0, 1'b0);
      send(2'd0, 8'h20, 1, 1'b0);

      // Backpressure with a spurious load_done during an increment WAIT.
      send(2'd0, 8'h05, 10, 1'b1);

      // Random commands.
      for (int i = 0; i < 20; i++) begin
         send(2'($urandom_range(0, 3)), W'($urandom), $urandom_range(0, 3), 1'b0);
      end

      // Reset during WAIT: the pulse already went out, its done must be discarded.
      ref_apply(2'd0, 8'h21);
      accept_cmd(2'd0, 8'h21);
      check("abort_pulse", inc_v, 1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      #1;
      check("abort_d1", in_ready, 0);
      @(negedge clk);
      check("abort_d2", in_ready, 0);
      @(negedge clk);
      check("abort_d3", in_ready, 0);
      @(negedge clk);
      check("abort_idle", in_ready, 1);
      repeat (4) begin
         check("abort_novalid", out_valid, 0);
         @(negedge clk);
      end
      send(2'd3, 8'h00, 0, 1'b0);

`ifdef ACCUMULATOR_COMMAND_SEQUENCER_TIMEOUT_EN
      begin
         int k;
         mute = 1'b1;
         accept_cmd(2'd0, 8'h33);
         k = 1;
         while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
         end
         check("tmo_latency", k, TMO + 1);
         check("tmo_error", out_err, 1);
         check("tmo_value", out_val, ref_val);
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         check("tmo_drain", in_ready, 0);
         mute = 1'b0;
         send(2'd3, 8'h00, 0, 1'b0);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
